// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - scan handshake and mux select/sample bundle
// master: the sequencer; slave: the consumer plus the scanned mux.
interface mux_scan_sequencer_if #(
  parameter int N_IN  = 8,
  parameter int SEL_W = 3
);
  logic             start;
  logic             mux_out;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             data_valid;
  logic [N_IN-1:0]  data_out;
  logic             parity_err;

  modport master (
    input  start, mux_out,
    output sel, busy, data_valid, data_out, parity_err
  );

  modport slave (
    output start, mux_out,
    input  sel, busy, data_valid, data_out, parity_err
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps an N:1 mux through every channel and assembles a word
// Optional SCAN_PARITY_EN: top channel is an even-parity bit, checked at end of scan.
module mux_scan_sequencer #(
  parameter int N_IN       = 8,
  parameter int SEL_W      = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_scan_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N_IN - 1);
  localparam bit               NO_SETTLE   = (SETTLE_CYC == 0);

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [N_IN-1:0]   shadow;
  logic [SEL_W-1:0]  sel_r;
  logic              busy_r;
  logic              valid_r;
  logic [N_IN-1:0]   data_r;
`ifdef SCAN_PARITY_EN
  logic              perr_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      shadow     <= '0;
      sel_r      <= '0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      data_r     <= '0;
`ifdef SCAN_PARITY_EN
      perr_r     <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sel_r      <= '0;
            settle_cnt <= 4'd0;
            busy_r     <= 1'b1;
            state      <= NO_SETTLE ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          // Compare-per-bit keeps the write legal when N_IN < 2**SEL_W.
          for (int i = 0; i < N_IN; i++) begin
            if (sel_r == SEL_W'(i)) shadow[i] <= bus.mux_out;
          end
          if (sel_r == SEL_LAST) begin
            state <= DONE;
          end else begin
            sel_r      <= sel_r + 1'b1;
            settle_cnt <= 4'd0;
            state      <= NO_SETTLE ? SAMPLE : SETTLE;
          end
        end
        DONE: begin
          data_r  <= shadow;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
`ifdef SCAN_PARITY_EN
          perr_r  <= ^shadow;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel_r;
  assign bus.busy       = busy_r;
  assign bus.data_valid = valid_r;
  assign bus.data_out   = data_r;
`ifdef SCAN_PARITY_EN
  assign bus.parity_err = perr_r;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - two builds (settle 2 and 0) scanning a modelled 8:1 mux
// Expected behaviour is derived from per-channel sample times, not from FSM states.
module tb_mux_scan_sequencer;
  localparam int N = 8;
  localparam int S_ARR [2] = '{2, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_word = 8'h00;

  mux_scan_sequencer_if #(.N_IN(8), .SEL_W(3)) bus0 ();
  mux_scan_sequencer_if #(.N_IN(8), .SEL_W(3)) bus1 ();

  assign bus0.start   = start;
  assign bus1.start   = start;
  assign bus0.mux_out = in_word[bus0.sel];
  assign bus1.mux_out = in_word[bus1.sel];

  mux_scan_sequencer #(.N_IN(8), .SEL_W(3), .SETTLE_CYC(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  mux_scan_sequencer #(.N_IN(8), .SEL_W(3), .SETTLE_CYC(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  always #5 clk = ~clk;

  logic [1:0] o_busy, o_dv, o_perr;
  logic [7:0] o_out [2];
  logic [2:0] o_sel [2];
  assign o_busy = {bus1.busy, bus0.busy};
  assign o_dv   = {bus1.data_valid, bus0.data_valid};
  assign o_perr = {bus1.parity_err, bus0.parity_err};
  assign o_out[0] = bus0.data_out;
  assign o_out[1] = bus1.data_out;
  assign o_sel[0] = bus0.sel;
  assign o_sel[1] = bus1.sel;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  bit         ever     [2];
  int         scan_s   [2];
  logic [7:0] asm_w    [2];
  logic [7:0] exp_out  [2];
  logic       exp_perr [2];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ever[d] = 1'b0; scan_s[d] = 0; asm_w[d] = '0; exp_out[d] = '0; exp_perr[d] = 1'b0;
    end
  endtask

  // Channel k of a scan begun at edge s is sampled at edge s+(S+1)*(k+1).
  task automatic model_edge(input int d, input bit st, input logic [7:0] w);
    int s1, len, rel, k;
    s1  = S_ARR[d] + 1;
    len = N * s1;
    if (ever[d]) begin
      rel = edge_n - scan_s[d];
      k   = rel / s1;
      if (rel > 0 && rel % s1 == 0 && k <= N) asm_w[d][k-1] = w[k-1];
      if (rel == len + 1) begin
        exp_out[d] = asm_w[d];
`ifdef SCAN_PARITY_EN
        exp_perr[d] = ^asm_w[d];
`endif
      end
    end
    if (st && (!ever[d] || edge_n - scan_s[d] >= len + 2)) begin
      ever[d]   = 1'b1;
      scan_s[d] = edge_n;
    end
  endtask

  task automatic check_outputs(input int d);
    int s1, len, rel, k;
    logic exp_busy, exp_dv;
    logic [2:0] exp_sel;
    s1  = S_ARR[d] + 1;
    len = N * s1;
    rel = edge_n - scan_s[d];
    k   = rel / s1;
    exp_busy = ever[d] && rel <= len;
    exp_dv   = ever[d] && rel == len + 1;
    exp_sel  = !ever[d] ? 3'd0 : (k > N - 1) ? 3'(N - 1) : 3'(k);
    chk("busy", d, 32'(o_busy[d]), 32'(exp_busy));
    chk("data_valid", d, 32'(o_dv[d]), 32'(exp_dv));
    chk("sel", d, 32'(o_sel[d]), 32'(exp_sel));
    chk("data_out", d, 32'(o_out[d]), 32'(exp_out[d]));
    chk("parity_err", d, 32'(o_perr[d]), 32'(exp_perr[d]));
  endtask

  task automatic step(input bit st, input logic [7:0] w);
    start   = st;
    in_word = w;
    @(posedge clk);
    edge_n++;
    if (rst_n) for (int d = 0; d < 2; d++) model_edge(d, st, w);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_outputs(d);
  endtask

  typedef struct {
    logic [7:0] w0;
    int         chg_at;
    logic [7:0] w1;
    int         xs0;
    int         xs1;
    logic [7:0] exp;
    logic       perr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int dvc;
    logic [7:0] cap;
    logic [7:0] w;
    logic perr_exp;

    vecs[0] = '{8'hA5, -1, 8'hA5, -1, -1, 8'hA5, 1'b0};
    vecs[1] = '{8'hA5, -1, 8'hA5,  5, 24, 8'hA5, 1'b0};
    vecs[2] = '{8'hA5, 16, 8'h3C, -1, -1, 8'h25, 1'b1};
    vecs[3] = '{8'h81, -1, 8'h81, -1, -1, 8'h81, 1'b0};
    vecs[4] = '{8'h01, -1, 8'h01, -1, -1, 8'h01, 1'b1};

    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

    // Directed scans on the settle-2 build.
    foreach (vecs[v]) begin
      dvc = 0;
      cap = '0;
      step(1'b1, vecs[v].w0);
      for (int r = 1; r < 30; r++) begin
        w = (vecs[v].chg_at >= 0 && r >= vecs[v].chg_at) ? vecs[v].w1 : vecs[v].w0;
        step(r == vecs[v].xs0 || r == vecs[v].xs1, w);
        if (r == 25) chk("vec_dv_at_25", v, 32'(o_dv[0]), 32'd1);
        if (o_dv[0]) begin dvc++; cap = o_out[0]; end
      end
`ifdef SCAN_PARITY_EN
      perr_exp = vecs[v].perr;
`else
      perr_exp = 1'b0;
`endif
      chk("vec_dv_count", v, 32'(dvc), 32'd1);
      chk("vec_data", v, 32'(cap), 32'(vecs[v].exp));
      chk("vec_perr", v, 32'(o_perr[0]), 32'(perr_exp));
    end

    // Random traffic against the model.
    w = 8'h00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) w = 8'($urandom);
      step($urandom_range(0, 7) == 0, w);
    end
    for (int i = 0; i < 30; i++) step(1'b0, w);

    // Settle-0 build: back-to-back scans, second start in the cycle after DONE.
    step(1'b1, 8'hFF);
    for (int r = 1; r <= 20; r++) begin
      step(r == 10, 8'hFF);
      if (r == 9 || r == 19) begin
        chk("b2b_dv", r, 32'(o_dv[1]), 32'd1);
        chk("b2b_data", r, 32'(o_out[1]), 32'hFF);
      end
    end
    for (int i = 0; i < 30; i++) step(1'b0, 8'hFF);

    // Reset at cycle 10 of a scan.
    step(1'b1, 8'h5A);
    for (int r = 1; r < 10; r++) step(1'b0, 8'h5A);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, 32'(o_busy[d]), 32'd0);
      chk("rst_dv", d, 32'(o_dv[d]), 32'd0);
      chk("rst_sel", d, 32'(o_sel[d]), 32'd0);
      chk("rst_data", d, 32'(o_out[d]), 32'd0);
      chk("rst_perr", d, 32'(o_perr[d]), 32'd0);
    end
    model_reset();
    step(1'b0, 8'h5A);
    step(1'b0, 8'h5A);
    rst_n = 1'b1;
    dvc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'h5A);
      if (o_dv != 2'b00) dvc++;
    end
    chk("post_rst_no_dv", 0, 32'(dvc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
